// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU result port, LSU result handshake and register-file write port.
interface wb_arbiter_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_W-1:0]  lsu_rd;
  logic [DATA_W-1:0] lsu_data;

  logic              Wen;
  logic [REG_W-1:0]  addr_D;
  logic [DATA_W-1:0] data_D;
  logic              busy;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, Wen, addr_D, data_D, busy
  );

  // Producer / register-file side
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, Wen, addr_D, data_D, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and FIFO-buffered LSU results onto the
// single register-file write port. ALU wins unless the starvation guard stalls it.
// Optional feature macro: WB_FWD_EN (adds combinational forwarding from the write port).
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] fwd_A,
  output logic [31:0] fwd_B,
  output logic        fwd_A_hit,
  output logic        fwd_B_hit
`endif
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned STV_W  = 8;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

  logic [REG_W-1:0]  rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;
  logic              alu_stall_q;
  logic              wen_q;
  logic [REG_W-1:0]  addr_q;
  logic [DATA_W-1:0] data_q;

  logic fifo_empty;
  logic lsu_ready_c;
  logic push;
  logic alu_sel;
  logic pop;

  // Handshake and arbitration decisions from registered state
  always_comb begin
    fifo_empty  = (count == '0);
    lsu_ready_c = rst_n & (count != CNT_FULL);
    push        = bus.lsu_valid & lsu_ready_c & (bus.lsu_rd != '0);
    alu_sel     = bus.alu_valid & (bus.alu_rd != '0) & ~alu_stall_q;
    pop         = ~fifo_empty & ~alu_sel;
  end

  // FIFO storage; only written on an accepted, non-x0 LSU transfer
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= bus.lsu_rd;
      data_mem[wr_ptr] <= bus.lsu_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation guard: count waiting cycles of the head, pulse alu_stall once at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt  <= '0;
      alu_stall_q <= 1'b0;
    end else begin
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STV_LIMIT) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
      alu_stall_q <= (starve_cnt == STV_LIMIT) & ~pop;
    end
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (alu_sel) begin
      wen_q  <= 1'b1;
      addr_q <= bus.alu_rd;
      data_q <= bus.alu_data;
    end else if (pop) begin
      wen_q  <= 1'b1;
      addr_q <= rd_mem[rd_ptr];
      data_q <= data_mem[rd_ptr];
    end else begin
      wen_q  <= 1'b0;
    end
  end

  assign bus.alu_stall = alu_stall_q;
  assign bus.lsu_ready = lsu_ready_c;
  assign bus.Wen       = wen_q;
  assign bus.addr_D    = addr_q;
  assign bus.data_D    = data_q;
  assign bus.busy      = ~fifo_empty;

`ifdef WB_FWD_EN
  // Forward the write in flight before the register file captures it
  assign fwd_A_hit = wen_q & (addr_q != '0) & (addr_q == rs1_addr);
  assign fwd_B_hit = wen_q & (addr_q != '0) & (addr_q == rs2_addr);
  assign fwd_A     = data_q;
  assign fwd_B     = data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_arbiter;

  localparam int unsigned LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  wb_arbiter_if bus ();

`ifdef WB_FWD_EN
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] fwd_A, fwd_B;
  logic        fwd_A_hit, fwd_B_hit;
`endif

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave)
`ifdef WB_FWD_EN
    ,
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .fwd_A     (fwd_A),
    .fwd_B     (fwd_B),
    .fwd_A_hit (fwd_A_hit),
    .fwd_B_hit (fwd_B_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        stall;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ar,
                              input logic [31:0] ad, input logic lv, input logic [4:0] lr,
                              input logic [31:0] ld, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic rdy, input logic b,
                              input logic s);
    vec_t v;
    v.rst_n = r;  v.alu_v = av; v.alu_rd = ar; v.alu_d = ad;
    v.lsu_v = lv; v.lsu_rd = lr; v.lsu_d = ld;
    v.wen = w; v.addr = a; v.data = d; v.ready = rdy; v.busy = b; v.stall = s;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ar,
                       input logic [31:0] ad, input logic lv, input logic [4:0] lr,
                       input logic [31:0] ld);
    rst_n = r;
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lr; bus.lsu_data = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Producer must never present an ALU result while stalled
  always @(posedge clk) begin
    if (rst_n && bus.alu_valid && bus.alu_stall) begin
      n_total++;
      $display("FAIL alu_protocol: alu_valid=1 while alu_stall=1 at %0t", $time);
    end
  end

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_FWD_EN
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
`endif

    //              rst av ard  alu_d          lv lrd  lsu_d         wen addr data           rdy busy stall
    vecs[0]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd1, 32'h11,     0, 5'd0,  32'h0,        0, 0, 0);
    vecs[1]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd1, 32'h11,     0, 5'd0,  32'h0,        0, 0, 0);
    vecs[2]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      0, 5'd0,  32'h0,        1, 0, 0);
    vecs[3]  = mk(1, 1, 5'd5,  32'h12345678, 0, 5'd0, 32'h0,      1, 5'd5,  32'h12345678, 1, 0, 0);
    vecs[4]  = mk(1, 1, 5'd0,  32'hFFFF,     0, 5'd0, 32'h0,      0, 5'd5,  32'h12345678, 1, 0, 0);
    vecs[5]  = mk(1, 1, 5'd3,  32'h33,       1, 5'd9, 32'h99,     1, 5'd3,  32'h33,       1, 1, 0);
    vecs[6]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      1, 5'd9,  32'h99,       1, 0, 0);
    vecs[7]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      0, 5'd9,  32'h99,       1, 0, 0);
    vecs[8]  = mk(1, 0, 5'd0,  32'h0,        1, 5'd0, 32'hDEAD,   0, 5'd9,  32'h99,       1, 0, 0);
    vecs[9]  = mk(1, 1, 5'd10, 32'hA1,       1, 5'd1, 32'h101,    1, 5'd10, 32'hA1,       1, 1, 0);
    vecs[10] = mk(1, 1, 5'd11, 32'hA2,       1, 5'd2, 32'h102,    1, 5'd11, 32'hA2,       1, 1, 0);
    vecs[11] = mk(1, 1, 5'd12, 32'hA3,       1, 5'd3, 32'h103,    1, 5'd12, 32'hA3,       1, 1, 0);
    vecs[12] = mk(1, 1, 5'd13, 32'hA4,       1, 5'd4, 32'h104,    1, 5'd13, 32'hA4,       0, 1, 0);
    vecs[13] = mk(1, 1, 5'd14, 32'hA5,       1, 5'd5, 32'h105,    1, 5'd14, 32'hA5,       0, 1, 0);
    vecs[14] = mk(1, 0, 5'd0,  32'h0,        1, 5'd5, 32'h105,    1, 5'd1,  32'h101,      1, 1, 0);
    vecs[15] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      1, 5'd2,  32'h102,      1, 1, 0);
    vecs[16] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      1, 5'd3,  32'h103,      1, 1, 0);
    vecs[17] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      1, 5'd4,  32'h104,      1, 0, 0);
    vecs[18] = mk(1, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      0, 5'd4,  32'h104,      1, 0, 0);

    // Table: reset, ALU-only, x0 filtering, simultaneous ALU/LSU, FIFO fill and ordered drain
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst_n, vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d,
            vecs[i].lsu_v, vecs[i].lsu_rd, vecs[i].lsu_d);
      step();
      chk("Wen",       i, 32'(bus.Wen),       32'(vecs[i].wen));
      chk("addr_D",    i, 32'(bus.addr_D),    32'(vecs[i].addr));
      chk("data_D",    i, bus.data_D,         vecs[i].data);
      chk("lsu_ready", i, 32'(bus.lsu_ready), 32'(vecs[i].ready));
      chk("busy",      i, 32'(bus.busy),      32'(vecs[i].busy));
      chk("alu_stall", i, 32'(bus.alu_stall), 32'(vecs[i].stall));
    end

    // Starvation: head rd=7 waits behind a continuous ALU stream
    drive(1'b1, 1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'hAA);
    step();
    chk("stv_push_addr", 0, 32'(bus.addr_D), 32'd20);
    chk("stv_push_busy", 0, 32'(bus.busy), 32'd1);
    bus.lsu_valid = 1'b0;
    for (int i = 1; i <= int'(LIMIT); i++) begin
      bus.alu_rd   = 5'd21;
      bus.alu_data = 32'h100 + 32'(i);
      step();
      chk("stv_wait_stall", i, 32'(bus.alu_stall), 32'd0);
      chk("stv_wait_data",  i, bus.data_D, 32'h100 + 32'(i));
    end
    step();
    chk("stv_pulse_stall", 0, 32'(bus.alu_stall), 32'd1);
    chk("stv_pulse_wen",   0, 32'(bus.Wen), 32'd1);
    bus.alu_valid = 1'b0;
    step();
    chk("stv_drain_wen",   0, 32'(bus.Wen), 32'd1);
    chk("stv_drain_addr",  0, 32'(bus.addr_D), 32'd7);
    chk("stv_drain_data",  0, bus.data_D, 32'hAA);
    chk("stv_drain_stall", 0, 32'(bus.alu_stall), 32'd0);
    chk("stv_drain_busy",  0, 32'(bus.busy), 32'd0);
    step();
    chk("stv_after_wen",   0, 32'(bus.Wen), 32'd0);
    chk("stv_after_stall", 0, 32'(bus.alu_stall), 32'd0);

    // Reset mid-operation discards buffered entry and pending write
    drive(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
    step();
    chk("mid_busy", 0, 32'(bus.busy), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("mid_rst_wen",   0, 32'(bus.Wen), 32'd0);
    chk("mid_rst_addr",  0, 32'(bus.addr_D), 32'd0);
    chk("mid_rst_data",  0, bus.data_D, 32'd0);
    chk("mid_rst_busy",  0, 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 0, 32'(bus.lsu_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_post_wen",  0, 32'(bus.Wen), 32'd0);
    chk("mid_post_busy", 0, 32'(bus.busy), 32'd0);

`ifdef WB_FWD_EN
    // Forwarding from the write in flight
    drive(1'b1, 1'b1, 5'd6, 32'h55, 1'b0, 5'd0, 32'd0);
    step();
    bus.alu_valid = 1'b0;
    rs1_addr = 5'd6;
    rs2_addr = 5'd7;
    #1;
    chk("fwd_A_hit", 0, 32'(fwd_A_hit), 32'd1);
    chk("fwd_A",     0, fwd_A, 32'h55);
    chk("fwd_B_hit", 0, 32'(fwd_B_hit), 32'd0);
    rst_n = 1'b0;
    rs1_addr = 5'd0;
    step();
    chk("fwd_x0_hit", 0, 32'(fwd_A_hit), 32'd0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
